// File: rtl/melody_seq.sv
// Melody sequencer: walks a fixed song table and drives the buzzer generator's period/enable with a per-note strobe.
// Optional `SEQ_GAP_EN inserts a silent gap of GAP_CNT_MAX+1 cycles after every note.
module melody_seq #(
  parameter logic [24:0] BEAT_CNT_MAX = 25'd24_999_999,
  parameter logic [24:0] GAP_CNT_MAX  = 25'd2_499_999,
  parameter logic [3:0]  SONG_LEN     = 4'd14,
  parameter logic [17:0] DO = 18'd190839,
  parameter logic [17:0] RE = 18'd170067,
  parameter logic [17:0] MI = 18'd151514,
  parameter logic [17:0] FA = 18'd143265,
  parameter logic [17:0] SO = 18'd127550,
  parameter logic [17:0] LA = 18'd113635,
  parameter logic [17:0] XI = 18'd101213
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        play,
  input  logic        stop,
  input  logic        loop_en,
  output logic [17:0] freq_data,
  output logic        tone_en,
  output logic        note_stb,
  output logic [3:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_NOTE = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]  state;
  logic [24:0] beat_cnt;
  logic [2:0]  beats_left;
  logic [6:0]  entry;
  logic [17:0] base;
  logic [17:0] period;
  logic        note_last;
  logic        last_entry;
  logic        adv;
`ifdef SEQ_GAP_EN
  logic [24:0] gap_cnt;
`endif

  // entry = {octave, note, beats}; unused slots are 1-beat rests
  function automatic logic [6:0] song_rom(input logic [3:0] i);
    case (i)
      4'd0:    song_rom = {1'b0, 3'd1, 3'd1};
      4'd1:    song_rom = {1'b0, 3'd1, 3'd1};
      4'd2:    song_rom = {1'b0, 3'd5, 3'd1};
      4'd3:    song_rom = {1'b0, 3'd5, 3'd1};
      4'd4:    song_rom = {1'b0, 3'd6, 3'd1};
      4'd5:    song_rom = {1'b0, 3'd6, 3'd1};
      4'd6:    song_rom = {1'b0, 3'd5, 3'd2};
      4'd7:    song_rom = {1'b0, 3'd4, 3'd1};
      4'd8:    song_rom = {1'b0, 3'd4, 3'd1};
      4'd9:    song_rom = {1'b0, 3'd3, 3'd1};
      4'd10:   song_rom = {1'b0, 3'd3, 3'd1};
      4'd11:   song_rom = {1'b0, 3'd2, 3'd1};
      4'd12:   song_rom = {1'b0, 3'd2, 3'd1};
      4'd13:   song_rom = {1'b0, 3'd1, 3'd2};
      default: song_rom = {1'b0, 3'd0, 3'd1};
    endcase
  endfunction

  always_comb begin
    entry = song_rom(note_idx);
    base  = freq_data;
    case (entry[5:3])
      3'd1:    base = DO;
      3'd2:    base = RE;
      3'd3:    base = MI;
      3'd4:    base = FA;
      3'd5:    base = SO;
      3'd6:    base = LA;
      3'd7:    base = XI;
      default: base = freq_data;
    endcase
    // a rest keeps the previous period untouched, octave or not
    if (entry[5:3] == 3'd0)
      period = freq_data;
    else if (entry[6])
      period = base >> 1;
    else
      period = base;
  end

  assign note_last  = (state == S_NOTE) && (beat_cnt == BEAT_CNT_MAX) && (beats_left == 3'd1);
  assign last_entry = (note_idx == SONG_LEN - 4'd1);
  assign busy       = (state != S_IDLE);

`ifdef SEQ_GAP_EN
  assign adv = (state == S_GAP) && (gap_cnt == GAP_CNT_MAX);
`else
  assign adv = note_last;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      freq_data  <= DO;
      tone_en    <= 1'b0;
      note_stb   <= 1'b0;
      note_idx   <= 4'd0;
      done       <= 1'b0;
      beat_cnt   <= 25'd0;
      beats_left <= 3'd0;
`ifdef SEQ_GAP_EN
      gap_cnt    <= 25'd0;
`endif
    end else begin
      note_stb <= 1'b0;
      done     <= 1'b0;
      if (stop) begin
        state      <= S_IDLE;
        tone_en    <= 1'b0;
        note_idx   <= 4'd0;
        beat_cnt   <= 25'd0;
        beats_left <= 3'd0;
`ifdef SEQ_GAP_EN
        gap_cnt    <= 25'd0;
`endif
      end else begin
        case (state)
          S_IDLE: if (play) state <= S_LOAD;
          S_LOAD: begin
            beats_left <= (entry[2:0] == 3'd0) ? 3'd1 : entry[2:0];
            freq_data  <= period;
            tone_en    <= (entry[5:3] != 3'd0);
            note_stb   <= 1'b1;
            beat_cnt   <= 25'd0;
            state      <= S_NOTE;
          end
          S_NOTE: begin
            if (beat_cnt == BEAT_CNT_MAX) begin
              beat_cnt   <= 25'd0;
              beats_left <= beats_left - 3'd1;
            end else begin
              beat_cnt <= beat_cnt + 25'd1;
            end
            if (note_last) begin
              tone_en <= 1'b0;
`ifdef SEQ_GAP_EN
              state   <= S_GAP;
`endif
            end
          end
          default: begin
`ifdef SEQ_GAP_EN
            gap_cnt <= (gap_cnt == GAP_CNT_MAX) ? 25'd0 : gap_cnt + 25'd1;
`else
            state   <= S_IDLE;
`endif
          end
        endcase
        // end of a note (and its gap): advance, wrap, or finish
        if (adv) begin
          if (!last_entry) begin
            note_idx <= note_idx + 4'd1;
            state    <= S_LOAD;
          end else if (loop_en) begin
            note_idx <= 4'd0;
            state    <= S_LOAD;
          end else begin
            note_idx <= 4'd0;
            done     <= 1'b1;
            state    <= S_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: per-cycle expected timeline built from the song table, driven by directed and random play/stop/loop stimulus.
module tb_melody_seq;
  localparam int BEAT = 10;
`ifdef SEQ_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif
  localparam int PASS_LEN = 14 + 16 * BEAT + 14 * GAP;
  localparam logic [17:0] F_DO = 18'd190839;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [17:0] freq_data;
  logic        tone_en;
  logic        note_stb;
  logic [3:0]  note_idx;
  logic        busy;
  logic        done;

  melody_seq #(.BEAT_CNT_MAX(25'd9), .GAP_CNT_MAX(25'd1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .play(play), .stop(stop), .loop_en(loop_en),
    .freq_data(freq_data), .tone_en(tone_en), .note_stb(note_stb), .note_idx(note_idx),
    .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        busy;
    logic        tone;
    logic        stb;
    logic        done;
    logic [3:0]  idx;
    logic [17:0] freq;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int n_chk = 0;
  int n_fail = 0;
  int n_stb, n_done, n_busy;

  int base_tbl[8]    = '{0, 190839, 170067, 151514, 143265, 127550, 113635, 101213};
  int song_note[14]  = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1};
  int song_beats[14] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic t, input logic s, input logic d,
                              input logic [3:0] i, input logic [17:0] f);
    exp_t e;
    e.busy = b; e.tone = t; e.stb = s; e.done = d; e.idx = i; e.freq = f;
    return e;
  endfunction

  // whole song(s) as a list of cycles: LOAD, beats*BEAT note cycles, optional gap
  task automatic push_song(input logic lp, input logic [17:0] f0);
    logic [17:0] f;
    int passes;
    f = f0;
    passes = lp ? 2 : 1;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < 14; i++) begin
        q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'(i), f));
        f = 18'(base_tbl[song_note[i]]);
        for (int c = 0; c < song_beats[i] * BEAT; c++)
          q.push_back(mk(1'b1, 1'b1, c == 0, 1'b0, 4'(i), f));
        for (int g = 0; g < GAP; g++)
          q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'(i), f));
      end
    end
    if (!lp) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, f));
  endtask

  // compare this cycle, then apply inputs for the coming edge and advance the model
  task automatic step(input logic p, input logic s, input logic r);
    logic [17:0] hold;
    @(negedge sys_clk);
    check("busy", busy, cur.busy);
    check("tone_en", tone_en, cur.tone);
    check("note_stb", note_stb, cur.stb);
    check("done", done, cur.done);
    check("note_idx", note_idx, cur.idx);
    check("freq_data", freq_data, cur.freq);
    n_stb  += int'(note_stb);
    n_done += int'(done);
    n_busy += int'(busy);
    play = p; stop = s; sys_rst = r;
    hold = r ? F_DO : cur.freq;
    if (r || s) q.delete();
    else if (p && !cur.busy) push_song(loop_en, cur.freq);
    if (q.size() > 0) cur = q.pop_front();
    else cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, hold);
  endtask

  task automatic clr_counts();
    n_stb = 0; n_done = 0; n_busy = 0;
  endtask

  initial begin
    int n, stop_at;
    cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, F_DO);
    clr_counts();
    @(posedge sys_clk);
    @(posedge sys_clk);

    // idle after reset
    repeat (20) step(1'b0, 1'b0, 1'b0);
    check("idle_stb_count", n_stb, 0);
    check("idle_busy_count", n_busy, 0);

    // full song, no loop
    loop_en = 1'b0;
    clr_counts();
    step(1'b1, 1'b0, 1'b0);
    repeat (PASS_LEN + 5) step(1'b0, 1'b0, 1'b0);
    check("song_stb_count", n_stb, 14);
    check("song_done_count", n_done, 1);
    check("song_busy_cycles", n_busy, PASS_LEN);

    // looping: wraps to entry 0 without done, then stop
    loop_en = 1'b1;
    clr_counts();
    step(1'b1, 1'b0, 1'b0);
    repeat (PASS_LEN + 20) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    loop_en = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("loop_stb_count", n_stb, 16);
    check("loop_done_count", n_done, 0);

    // stop with simultaneous play mid entry 3; play while busy ignored
    clr_counts();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(i == 10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    check("stop_done_count", n_done, 0);
    check("stop_stb_count", n_stb, 4);

    // synchronous reset while a note sounds
    step(1'b1, 1'b0, 1'b0);
    repeat (28) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0);

    // random play/stop/loop traffic
    for (int it = 0; it < 10; it++) begin
      step(1'b0, 1'b1, 1'b0);
      loop_en = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 10)) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      n = loop_en ? int'($urandom_range(20, PASS_LEN + 100)) : int'($urandom_range(20, PASS_LEN + 60));
      stop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, n - 1)) : -1;
      for (int c = 0; c < n; c++)
        step($urandom_range(0, 15) == 0, c == stop_at, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
